mod_counter: RTL and testbench

Parametrised modulo up/down counter with load, programmable step, ce prescaler, wrap/saturate mode, terminal-count pulse and sticky overflow flag. Next-generation replacement for the fixed-width counter in the verification sessions. Used standalone as a DUT and as a timebase for later blocks.

---
 rtl/mod_counter_pkg.sv | 12 +
 rtl/mod_counter_prescaler.sv | 29 ++
 rtl/mod_counter.sv | 121 ++++++++++++
 tb/tb_mod_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types and constants for the modulo counter.
package mod_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : mod_counter_pkg

// File: rtl/mod_counter_prescaler.sv
// Divides ce into count ticks: one tick every PRESCALE ce-high cycles.
module mod_counter_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ce,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  // Tick on the last ce-high cycle of the prescale window.
  assign tick = ce && (cnt == LAST);

  // Prescale counter; clr restarts the window, ce low freezes it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (ce) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule : mod_counter_prescaler

// File: rtl/mod_counter.sv
// Modulo up/down counter with load, step, prescaler, wrap/saturate,
// terminal-count pulse and sticky boundary flag.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MOD      = 2 ** WIDTH,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned STEP_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_n,
  input  logic [WIDTH-1:0]  data_load,
  input  logic              ce,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  mode_e             mode,
  input  logic              ovf_clr,
  output logic [WIDTH-1:0]  count_out,
  output logic              zero,
  output logic              max_count,
  output logic              tc,
  output logic              ovf_sticky
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH:0]   MAX_X = {1'b0, MAX_V};

  // Elaboration-time parameter legality.
  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("mod_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_counter: PRESCALE must be >= 1");
  end
  if ((1 << STEP_W) > MOD) begin : g_bad_step
    $error("mod_counter: 2**STEP_W must be <= MOD");
  end

  logic             tick;
  logic             load;
  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH-1:0] count_nxt_c;
  logic             event_c;
  logic [WIDTH-1:0] load_val_c;

  assign load = ~load_n;

  mod_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .ce   (ce),
    .tick (tick)
  );

  assign cnt_x  = {1'b0, count_out};
  assign step_x = (WIDTH + 1)'(step);
  assign sum_x  = cnt_x + step_x;

  // Out-of-range load values clamp to the top of the range.
  assign load_val_c = ({1'b0, data_load} >= MOD_X) ? MAX_V : data_load;

  // Next count and boundary detection for a tick, at WIDTH+1 bits.
  always_comb begin
    count_nxt_c = count_out;
    event_c     = 1'b0;
    if (up_down == DIR_UP) begin
      if (sum_x <= MAX_X) begin
        count_nxt_c = sum_x[WIDTH-1:0];
      end else begin
        event_c     = 1'b1;
        count_nxt_c = (mode == MODE_SAT) ? MAX_V : WIDTH'(sum_x - MOD_X);
      end
    end else begin
      if (step_x <= cnt_x) begin
        count_nxt_c = WIDTH'(cnt_x - step_x);
      end else begin
        event_c     = 1'b1;
        count_nxt_c = (mode == MODE_SAT) ? '0 : WIDTH'(cnt_x + MOD_X - step_x);
      end
    end
  end

  // Count register and terminal-count pulse; load beats tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_out <= '0;
      tc        <= 1'b0;
    end else if (load) begin
      count_out <= load_val_c;
      tc        <= 1'b0;
    end else if (tick) begin
      count_out <= count_nxt_c;
      tc        <= event_c;
    end else begin
      tc        <= 1'b0;
    end
  end

  // Sticky boundary flag; a same-edge event beats the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (load_n && tick && event_c) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

  assign zero      = (count_out == '0);
  assign max_count = (count_out == MAX_V);

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter with WIDTH=4, MOD=10, PRESCALE=3, STEP_W=2.
module tb_mod_counter;
  import mod_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_n;
  logic [3:0] data_load;
  logic       ce;
  logic       up_down;
  logic [1:0] step;
  mode_e      mode;
  logic       ovf_clr;
  logic [3:0] count_out;
  logic       zero;
  logic       max_count;
  logic       tc;
  logic       ovf_sticky;

  int total = 0;
  int bad   = 0;

  mod_counter #(
    .WIDTH    (4),
    .MOD      (10),
    .PRESCALE (3),
    .STEP_W   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_n     (load_n),
    .data_load  (data_load),
    .ce         (ce),
    .up_down    (up_down),
    .step       (step),
    .mode       (mode),
    .ovf_clr    (ovf_clr),
    .count_out  (count_out),
    .zero       (zero),
    .max_count  (max_count),
    .tc         (tc),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load_n = 1'b0; data_load = v; ce = 1'b0; ovf_clr = 1'b0;
    edge1();
    load_n = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_n = 1'b0; data_load = 4'd5; ce = 1'b1;
    up_down = DIR_UP; step = 2'd1; mode = MODE_WRAP; ovf_clr = 1'b0;
    edge1();
    total++; if (count_out !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_out); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", zero); end
    total++; if (max_count !== 1'b0) begin bad++; $display("FAIL reset_max got=%b exp=0", max_count); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b exp=0", tc); end
    total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_sticky); end
    rst = 1'b0; load_n = 1'b1; ce = 1'b0;
  endtask

  task automatic test_prescale();
    logic [3:0] exp_seq [9] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3};
    up_down = DIR_UP; step = 2'd1; mode = MODE_WRAP; ce = 1'b1;
    for (int i = 0; i < 9; i++) begin
      edge1();
      total++;
      if (count_out !== exp_seq[i]) begin
        bad++; $display("FAIL prescale_%0d got=%0d exp=%0d", i, count_out, exp_seq[i]);
      end
    end
    ce = 1'b0;
  endtask

  task automatic test_wrap_up();
    do_load(4'd8);
    total++; if (count_out !== 4'd8) begin bad++; $display("FAIL wrap_load got=%0d exp=8", count_out); end
    step = 2'd3; up_down = DIR_UP; mode = MODE_WRAP; ce = 1'b1;
    edge1(); edge1();
    total++; if (count_out !== 4'd8 || tc !== 1'b0) begin bad++; $display("FAIL wrap_pre got=%0d/%b exp=8/0", count_out, tc); end
    edge1();
    total++; if (count_out !== 4'd1) begin bad++; $display("FAIL wrap_count got=%0d exp=1", count_out); end
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL wrap_tc got=%b exp=1", tc); end
    total++; if (ovf_sticky !== 1'b1) begin bad++; $display("FAIL wrap_ovf got=%b exp=1", ovf_sticky); end
    ce = 1'b0;
    edge1();
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL wrap_tc_drop got=%b exp=0", tc); end
    total++; if (ovf_sticky !== 1'b1) begin bad++; $display("FAIL wrap_ovf_hold got=%b exp=1", ovf_sticky); end
    ovf_clr = 1'b1;
    edge1();
    ovf_clr = 1'b0;
    total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL wrap_ovf_clr got=%b exp=0", ovf_sticky); end
  endtask

  task automatic test_sat_down();
    logic exp_tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_load(4'd1);
    step = 2'd2; up_down = DIR_DOWN; mode = MODE_SAT; ce = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edge1();
      total++;
      if (tc !== exp_tc[i]) begin bad++; $display("FAIL satdn_tc_%0d got=%b exp=%b", i, tc, exp_tc[i]); end
    end
    total++; if (count_out !== 4'd0) begin bad++; $display("FAIL satdn_count got=%0d exp=0", count_out); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL satdn_zero got=%b exp=1", zero); end
    total++; if (ovf_sticky !== 1'b1) begin bad++; $display("FAIL satdn_ovf got=%b exp=1", ovf_sticky); end
    ce = 1'b0;
  endtask

  task automatic test_sat_up();
    do_load(4'd8);
    step = 2'd3; up_down = DIR_UP; mode = MODE_SAT; ce = 1'b1;
    edge1(); edge1(); edge1();
    total++; if (count_out !== 4'd9 || tc !== 1'b1) begin bad++; $display("FAIL satup_1 got=%0d/%b exp=9/1", count_out, tc); end
    total++; if (max_count !== 1'b1) begin bad++; $display("FAIL satup_max got=%b exp=1", max_count); end
    edge1(); edge1(); edge1();
    total++; if (count_out !== 4'd9 || tc !== 1'b1) begin bad++; $display("FAIL satup_2 got=%0d/%b exp=9/1", count_out, tc); end
    ce = 1'b0;
  endtask

  task automatic test_down_wrap_and_hold();
    do_load(4'd1);
    step = 2'd3; up_down = DIR_DOWN; mode = MODE_WRAP; ce = 1'b1;
    edge1(); edge1(); edge1();
    total++; if (count_out !== 4'd8 || tc !== 1'b1) begin bad++; $display("FAIL dnwrap got=%0d/%b exp=8/1", count_out, tc); end
    step = 2'd0;
    edge1(); edge1(); edge1();
    total++; if (count_out !== 4'd8 || tc !== 1'b0) begin bad++; $display("FAIL step0 got=%0d/%b exp=8/0", count_out, tc); end
    ce = 1'b0;
  endtask

  task automatic test_clamp_priority();
    do_load(4'd2);
    step = 2'd1; up_down = DIR_UP; mode = MODE_WRAP; ce = 1'b1;
    edge1(); edge1();
    load_n = 1'b0; data_load = 4'd14;
    edge1();
    load_n = 1'b1;
    total++; if (count_out !== 4'd9) begin bad++; $display("FAIL clamp_count got=%0d exp=9", count_out); end
    total++; if (max_count !== 1'b1) begin bad++; $display("FAIL clamp_max got=%b exp=1", max_count); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL clamp_tc got=%b exp=0", tc); end
    edge1(); edge1();
    total++; if (count_out !== 4'd9 || tc !== 1'b0) begin bad++; $display("FAIL clamp_restart got=%0d/%b exp=9/0", count_out, tc); end
    edge1();
    total++; if (count_out !== 4'd0 || tc !== 1'b1) begin bad++; $display("FAIL clamp_tick got=%0d/%b exp=0/1", count_out, tc); end
    ce = 1'b0;
  endtask

  task automatic test_sticky_race();
    ovf_clr = 1'b1;
    edge1();
    do_load(4'd9);
    step = 2'd1; up_down = DIR_UP; mode = MODE_WRAP; ce = 1'b1;
    edge1(); edge1();
    ovf_clr = 1'b1;
    edge1();
    ovf_clr = 1'b0;
    total++; if (ovf_sticky !== 1'b1) begin bad++; $display("FAIL race_ovf got=%b exp=1", ovf_sticky); end
    total++; if (count_out !== 4'd0 || tc !== 1'b1) begin bad++; $display("FAIL race_count got=%0d/%b exp=0/1", count_out, tc); end
    ce = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_load(4'd4);
    step = 2'd1; up_down = DIR_UP; mode = MODE_WRAP; ce = 1'b1;
    edge1(); edge1();
    rst = 1'b1; load_n = 1'b0; data_load = 4'd7;
    edge1();
    rst = 1'b0; load_n = 1'b1;
    total++; if (count_out !== 4'd0 || tc !== 1'b0) begin bad++; $display("FAIL midrst_count got=%0d/%b exp=0/0", count_out, tc); end
    total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b exp=0", ovf_sticky); end
    edge1(); edge1();
    total++; if (count_out !== 4'd0) begin bad++; $display("FAIL midrst_pre got=%0d exp=0", count_out); end
    edge1();
    total++; if (count_out !== 4'd1) begin bad++; $display("FAIL midrst_tick got=%0d exp=1", count_out); end
    ce = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_wrap_up();
    test_sat_down();
    test_sat_up();
    test_down_wrap_and_hold();
    test_clamp_priority();
    test_sticky_race();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mod_counter
